// File: rtl/datainf_master_incr_gen_if.sv
// data_inf valid/ready bus: one data word per valid & ready handshake.
// Ports: valid (master->slave), ready (slave->master), data (master->slave, DSIZE bits).
// master modport drives valid/data and samples ready; slave modport is the mirror.
interface datainf_master_incr_gen_if #(
  parameter int DSIZE = 8
);
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/datainf_master_incr_gen.sv
// Purpose: on start, emits length_i words counting up from seed_i on a data_inf master port.
// Latency: first word 1 cycle after start; done_o 1 cycle after last handshake; 1 word/cycle at ready=1.
// Backpressure: valid/data held stable while ready is low; start ignored while a burst runs.
// Ports: clock, rst (sync, active-high); start_i/length_i/seed_i request a burst (sampled in IDLE);
//        busy_o high while running; done_o 1-cycle completion pulse; master = data_inf source.
module datainf_master_incr_gen #(
  parameter int DSIZE = 8,
  parameter int LSIZE = 16
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [LSIZE-1:0]          length_i,
  input  logic [DSIZE-1:0]          seed_i,
  output logic                      busy_o,
  output logic                      done_o,
  datainf_master_incr_gen_if.master master
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [LSIZE-1:0] cnt_q,   cnt_d;
  logic [LSIZE-1:0] len_q,   len_d;
  logic [DSIZE-1:0] data_q,  data_d;
  logic             done_q,  done_d;
  logic             hs;
  logic             last_beat;

  // valid and busy are both exactly "in RUN": valid rises the cycle after
  // start and can only fall after the final handshake.
  assign master.valid = (state_q == ST_RUN);
  assign master.data  = data_q;
  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = done_q;

  assign hs        = master.valid & master.ready;
  // len_q is never 0 in RUN, so len_q-1 cannot underflow here.
  assign last_beat = (cnt_q == len_q - LSIZE'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (length_i != '0) begin
            len_d   = length_i;
            data_d  = seed_i;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            // Empty burst completes immediately without raising valid.
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (hs) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            data_d = data_q + DSIZE'(1);
            cnt_d  = cnt_q + LSIZE'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_datainf_master_incr_gen.sv
module tb_datainf_master_incr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] length;
  logic [7:0]  seed;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  datainf_master_incr_gen_if #(.DSIZE(8)) mif ();

  datainf_master_incr_gen #(.DSIZE(8), .LSIZE(16)) dut (
    .clock    (clk),
    .rst      (rst),
    .start_i  (start),
    .length_i (length),
    .seed_i   (seed),
    .busy_o   (busy),
    .done_o   (done),
    .master   (mif)
  );

  always #5 clk = ~clk;

  // Observation record filled by run_burst; each test judges it against its own model.
  logic [7:0] hs_data[$];
  int         hs_cyc[$];
  int done_cnt, first_done, busy_cnt, hold_err, overlap, first_valid, valid_after_done;
  logic rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Presents start at cycle 0 (and again at extra_start) and records ncyc cycles.
  // mode 0: ready=1, mode 1: fixed pattern from cycle 1, mode 2: random ready.
  task automatic run_burst(input int len, input logic [7:0] sd, input int mode,
                           input int extra_start, input int ncyc);
    logic       pend;
    logic [7:0] pdata;
    hs_data.delete(); hs_cyc.delete();
    done_cnt = 0; first_done = -1; busy_cnt = 0; hold_err = 0; overlap = 0;
    first_valid = -1; valid_after_done = 0; pend = 1'b0; pdata = '0;
    for (int k = 0; k < ncyc; k++) begin
      start  = (k == 0) || (k == extra_start);
      length = 16'(len);
      seed   = sd;
      case (mode)
        0:       mif.ready = 1'b1;
        1:       mif.ready = (k >= 1 && k <= 6) ? rdy_pat[k-1] : 1'b1;
        default: mif.ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mif.valid && first_valid < 0) first_valid = k;
      if (pend && (!mif.valid || mif.data !== pdata)) hold_err++;
      if (mif.valid && done_cnt > 0) valid_after_done++;
      if (mif.valid && mif.ready) begin
        hs_data.push_back(mif.data);
        hs_cyc.push_back(k);
      end
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (busy) busy_cnt++;
      if (done && busy) overlap++;
      pend  = mif.valid && !mif.ready;
      pdata = mif.data;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; length = '0; seed = '0; mif.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (mif.valid !== 1'b0 || mif.data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h busy=%b done=%b, required 0 00 0 0",
               mif.valid, mif.data, busy, done);
    end
  endtask

  task automatic test_basic;
    run_burst(4, 8'h10, 0, -1, 10);
    checks++;
    if (hs_data.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d handshakes, required 4", hs_data.size());
    end
    for (int i = 0; i < hs_data.size() && i < 4; i++) begin
      checks++;
      if (hs_data[i] !== 8'(8'h10 + i) || hs_cyc[i] != i + 1) begin
        errors++;
        $display("FAIL basic_word%0d: data=%h at cycle %0d, required %h at cycle %0d",
                 i, hs_data[i], hs_cyc[i], 8'(8'h10 + i), i + 1);
      end
    end
    checks++;
    if (first_done != 5 || done_cnt != 1 || busy_cnt != 4 || overlap != 0) begin
      errors++;
      $display("FAIL basic_done_busy: done@%0d x%0d busy=%0d overlap=%0d, required done@5 x1 busy=4 overlap=0",
               first_done, done_cnt, busy_cnt, overlap);
    end
  endtask

  task automatic test_backpressure;
    int exp_cyc [3] = '{1, 4, 6};
    run_burst(3, 8'h05, 1, -1, 12);
    checks++;
    if (hs_data.size() != 3 || hold_err != 0) begin
      errors++;
      $display("FAIL bp_count_hold: handshakes=%0d hold_errors=%0d, required 3 and 0",
               hs_data.size(), hold_err);
    end
    for (int i = 0; i < hs_data.size() && i < 3; i++) begin
      checks++;
      if (hs_data[i] !== 8'(8'h05 + i) || hs_cyc[i] != exp_cyc[i]) begin
        errors++;
        $display("FAIL bp_word%0d: data=%h at cycle %0d, required %h at cycle %0d",
                 i, hs_data[i], hs_cyc[i], 8'(8'h05 + i), exp_cyc[i]);
      end
    end
    checks++;
    if (first_done != 7 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_done: done@%0d x%0d, required done@7 x1", first_done, done_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_burst(4, 8'hFE, 0, -1, 8);
    checks++;
    if (hs_data.size() != 4 || first_done != 5) begin
      errors++;
      $display("FAIL wrap_count: handshakes=%0d done@%0d, required 4 and done@5",
               hs_data.size(), first_done);
    end
    for (int i = 0; i < hs_data.size() && i < 4; i++) begin
      checks++;
      if (hs_data[i] !== exp[i]) begin
        errors++;
        $display("FAIL wrap_word%0d: data=%h, required %h", i, hs_data[i], exp[i]);
      end
    end
  endtask

  task automatic test_zero_length;
    run_burst(0, 8'h33, 0, -1, 5);
    checks++;
    if (first_valid != -1 || busy_cnt != 0 || done_cnt != 1 || first_done != 1) begin
      errors++;
      $display("FAIL zero_len: first_valid=%0d busy=%0d done@%0d x%0d, required -1 0 done@1 x1",
               first_valid, busy_cnt, first_done, done_cnt);
    end
  endtask

  task automatic test_start_during_run;
    logic [7:0] sd;
    sd = 8'($urandom);
    run_burst(6, sd, 0, 3, 18);
    checks++;
    if (hs_data.size() != 6 || done_cnt != 1 || valid_after_done != 0 || first_done != 7) begin
      errors++;
      $display("FAIL start_in_run: handshakes=%0d done@%0d x%0d valid_after_done=%0d, required 6 done@7 x1 0",
               hs_data.size(), first_done, done_cnt, valid_after_done);
    end
    for (int i = 0; i < hs_data.size() && i < 6; i++) begin
      checks++;
      if (hs_data[i] !== 8'(sd + i)) begin
        errors++;
        $display("FAIL start_in_run_word%0d: data=%h, required %h", i, hs_data[i], 8'(sd + i));
      end
    end
  endtask

  task automatic test_reset_midburst;
    int  nhs;
    logic stray;
    start = 1'b1; length = 16'd8; seed = 8'h70; mif.ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; nhs = 0;
    for (int k = 0; k < 2; k++) begin
      if (mif.valid && mif.ready) nhs++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (nhs != 2 || mif.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: handshakes=%0d valid=%b busy=%b done=%b, required 2 0 0 0",
               nhs, mif.valid, busy, done);
    end
    stray = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done || mif.valid) stray = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL rst_mid_quiet: done/valid seen after reset, required none");
    end
    run_burst(2, 8'h40, 0, -1, 6);
    checks++;
    if (hs_data.size() != 2 || first_done != 3 || done_cnt != 1 ||
        (hs_data.size() == 2 && (hs_data[0] !== 8'h40 || hs_data[1] !== 8'h41))) begin
      errors++;
      $display("FAIL rst_mid_restart: handshakes=%0d done@%0d x%0d, required 40,41 done@3 x1",
               hs_data.size(), first_done, done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic       ev [10];
    logic       ed [10];
    logic [7:0] edat [10];
    // Model: burst A (len 3, 0x20) starts at 0; B (len 2, 0x80) is requested on A's done cycle.
    for (int k = 0; k < 10; k++) begin
      ev[k] = (k >= 1 && k <= 3) || (k >= 5 && k <= 6);
      ed[k] = (k == 4) || (k == 7);
      edat[k] = (k <= 3) ? 8'(8'h20 + k - 1) : 8'(8'h80 + k - 5);
    end
    mif.ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      start  = (k == 0) || (k == 4);
      length = (k == 0) ? 16'd3 : 16'd2;
      seed   = (k == 0) ? 8'h20 : 8'h80;
      checks++;
      if (mif.valid !== ev[k] || done !== ed[k] || (ev[k] && mif.data !== edat[k])) begin
        errors++;
        $display("FAIL b2b_cycle%0d: valid=%b done=%b data=%h, required valid=%b done=%b data=%h",
                 k, mif.valid, done, mif.data, ev[k], ed[k], edat[k]);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_random;
    int         len;
    logic [7:0] sd;
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 12);
      sd  = 8'($urandom);
      run_burst(len, sd, 2, -1, 8 * len + 12);
      checks++;
      if (hs_data.size() != len || done_cnt != 1 || hold_err != 0 || overlap != 0 ||
          first_valid != 1 || valid_after_done != 0) begin
        errors++;
        $display("FAIL rand%0d_summary: hs=%0d/%0d done x%0d hold_err=%0d overlap=%0d first_valid=%0d",
                 b, hs_data.size(), len, done_cnt, hold_err, overlap, first_valid);
      end else begin
        checks++;
        if (first_done != hs_cyc[len-1] + 1) begin
          errors++;
          $display("FAIL rand%0d_done_timing: done@%0d, required %0d", b, first_done, hs_cyc[len-1] + 1);
        end
      end
      for (int i = 0; i < hs_data.size() && i < len; i++) begin
        checks++;
        if (hs_data[i] !== 8'(sd + i)) begin
          errors++;
          $display("FAIL rand%0d_word%0d: data=%h, required %h", b, i, hs_data[i], 8'(sd + i));
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_zero_length;
    test_start_during_run;
    test_reset_midburst;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
